// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor.
// Operands are signed 32-bit; results are signed 64-bit so no operation can overflow.
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);
  localparam int OPND_W      = 32;
  localparam int RES_W       = 64;

  typedef logic signed [OPND_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;
  typedef logic [ADDR_W-1:0]        address_t;
  typedef logic [ADDR_W:0]          count_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT
  } state_t;

endpackage

// File: rtl/instr_exec_reader_if.sv
// Sweep control, instruction-register read port and result stream of the executor.
// slave is the executor side; master is the side that commands it and consumes results.
interface instr_exec_reader_if;
  import instr_register_pkg::*;

  logic         start;
  address_t     start_addr;
  count_t       count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  result_t      res_data;
  opcode_t      res_opcode;
  address_t     res_addr;
  logic         res_err;
  logic         busy;
  logic         done;

  modport master (
    output start, start_addr, count, instruction_word, res_ready,
    input  read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
  );

  modport slave (
    input  start, start_addr, count, instruction_word, res_ready,
    output read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
  );

endinterface

// File: rtl/instr_alu.sv
// Combinational evaluator: one instruction in, signed 64-bit result and error flag out.
// Divide/modulo by zero and undefined opcodes give zero with the error flag set.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t i_instr,
  output result_t      o_result,
  output logic         o_err
);

  result_t w_a;
  result_t w_b;

  assign w_a = {{(RES_W-OPND_W){i_instr.op_a[OPND_W-1]}}, i_instr.op_a};
  assign w_b = {{(RES_W-OPND_W){i_instr.op_b[OPND_W-1]}}, i_instr.op_b};

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_instr.opc)
      ZERO:  o_result = '0;
      PASSA: o_result = w_a;
      PASSB: o_result = w_b;
      ADD:   o_result = w_a + w_b;
      SUB:   o_result = w_a - w_b;
      MULT:  o_result = w_a * w_b;
      DIV: begin
        if (w_b == '0) o_err    = 1'b1;
        else           o_result = w_a / w_b;
      end
      MOD: begin
        if (w_b == '0) o_err    = 1'b1;
        else           o_result = w_a % w_b;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_reader.sv
// Read-side sweeper: walks read_pointer over a window, evaluates each stored
// instruction and streams results over valid/ready, pulsing done after the last.
//
// state   | meaning
// S_IDLE  | waiting for start; count==0 start just pulses done
// S_FETCH | read_pointer stable, instruction_word sampled at cycle end
// S_EXEC  | sampled word evaluated, result registered
// S_OUT   | result held until res_ready, then next entry or finish
module instr_exec_reader
  import instr_register_pkg::*;
(
  input logic                clk,
  input logic                reset,
  instr_exec_reader_if.slave bus
);

  state_t       r_state;
  state_t       w_next;
  address_t     r_ptr;
  count_t       r_remaining;
  instruction_t r_word;
  logic         r_res_valid;
  result_t      r_res_data;
  opcode_t      r_res_opcode;
  address_t     r_res_addr;
  logic         r_res_err;
  logic         r_busy;
  logic         r_done;

  logic         w_load;
  logic         w_zero_start;
  logic         w_sample;
  logic         w_exec;
  logic         w_accept;
  logic         w_last;
  result_t      w_alu_result;
  logic         w_alu_err;

  instr_alu u_alu (
    .i_instr  (r_word),
    .o_result (w_alu_result),
    .o_err    (w_alu_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && bus.count != '0) w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = S_OUT;
      S_OUT: begin
        if (bus.res_ready) w_next = (r_remaining == count_t'(1)) ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load       = (r_state == S_IDLE) && bus.start && (bus.count != '0);
    w_zero_start = (r_state == S_IDLE) && bus.start && (bus.count == '0);
    w_sample     = (r_state == S_FETCH);
    w_exec       = (r_state == S_EXEC);
    w_accept     = (r_state == S_OUT) && bus.res_ready;
    w_last       = w_accept && (r_remaining == count_t'(1));
  end

  // Pointer advances only on acceptance so it stays put while results back up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_word       <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= ZERO;
      r_res_addr   <= '0;
      r_res_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_zero_start | w_last;
      if (w_load) begin
        r_ptr       <= bus.start_addr;
        r_remaining <= bus.count;
        r_busy      <= 1'b1;
      end
      if (w_sample) r_word <= bus.instruction_word;
      if (w_exec) begin
        r_res_valid  <= 1'b1;
        r_res_data   <= w_alu_result;
        r_res_opcode <= r_word.opc;
        r_res_addr   <= r_ptr;
        r_res_err    <= w_alu_err;
      end
      if (w_accept) begin
        r_res_valid <= 1'b0;
        r_remaining <= r_remaining - count_t'(1);
        if (w_last) r_busy <= 1'b0;
        else        r_ptr  <= r_ptr + address_t'(1);
      end
    end
  end

  assign bus.read_pointer = r_ptr;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_opcode   = r_res_opcode;
  assign bus.res_addr     = r_res_addr;
  assign bus.res_err      = r_res_err;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_instr_exec_reader.sv
// Scoreboard bench for instr_exec_reader: directed sweeps push hand-computed
// results, a negedge monitor pops and compares each accepted result.
module tb_instr_exec_reader;
  import instr_register_pkg::*;

  typedef struct {
    result_t  data;
    opcode_t  opc;
    address_t addr;
    logic     err;
  } exp_t;

  logic clk;
  logic reset;
  instr_exec_reader_if bus ();

  instruction_t mem [NUM_ENTRIES];
  exp_t         exp_q [$];
  int           n_checks;
  int           n_errors;
  int           res_cnt;
  int           done_cnt;

  instr_exec_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.instruction_word = mem[bus.read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input result_t d, input opcode_t o, input address_t a, input logic e);
    exp_t x;
    x.data = d; x.opc = o; x.addr = a; x.err = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) done_cnt++;
    if (!reset && bus.res_valid && bus.res_ready) begin
      res_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got data %0h addr %0d, none expected", bus.res_data, bus.res_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data",     bus.res_data,     e.data);
        check("res_opcode",   bus.res_opcode,   e.opc);
        check("res_addr",     bus.res_addr,     e.addr);
        check("read_pointer", bus.read_pointer, e.addr);
        check("res_err",      bus.res_err,      e.err);
      end
    end
  end

  // Called at #1 after an edge; leaves start low at #1 after the start edge.
  task automatic start_pulse(input address_t a, input count_t c);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.count      = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!bus.res_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_res_valid", bus.res_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("busy_clear", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_read_pointer", bus.read_pointer, 0);
    check("rst_res_valid",    bus.res_valid,    0);
    check("rst_res_data",     bus.res_data,     0);
    check("rst_res_opcode",   bus.res_opcode,   ZERO);
    check("rst_res_addr",     bus.res_addr,     0);
    check("rst_res_err",      bus.res_err,      0);
    check("rst_busy",         bus.busy,         0);
    check("rst_done",         bus.done,         0);
  endtask

  task automatic push_basic4();
    push(64'sd8,   ADD,  5'd0, 1'b0);
    push(-64'sd3,  SUB,  5'd1, 1'b0);
    push(-64'sd24, MULT, 5'd2, 1'b0);
    push(64'sd3,   DIV,  5'd3, 1'b0);
  endtask

  initial begin
    int lat;
    int d0;
    int r0;
    n_checks = 0; n_errors = 0; res_cnt = 0; done_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.count = '0; bus.res_ready = 1'b1;
    for (int i = 0; i < NUM_ENTRIES; i++) mem[i] = '{ZERO, 32'sd0, 32'sd0};
    mem[0]  = '{ADD,   32'sd5,  32'sd3};
    mem[1]  = '{SUB,   32'sd5,  32'sd8};
    mem[2]  = '{MULT, -32'sd4,  32'sd6};
    mem[3]  = '{DIV,   32'sd7,  32'sd2};
    mem[4]  = '{DIV,   32'sd9,  32'sd0};
    mem[5]  = '{MOD,  -32'sd7,  32'sd0};
    mem[6]  = '{MOD,  -32'sd7,  32'sd2};
    mem[7]  = '{PASSA, -32'sd5, 32'sd9};
    mem[8]  = '{PASSB, 32'sd1, -32'sd2};
    mem[9]  = '{ZERO,  32'sd77, 32'sd66};
    mem[10] = '{opcode_t'(4'hB), 32'sd4, 32'sd4};
    mem[11] = '{DIV,  32'sh8000_0000, -32'sd1};
    mem[12] = '{MULT, 32'sh7fff_ffff, 32'sh7fff_ffff};
    mem[13] = '{DIV,  -32'sd7, 32'sd2};
    mem[30] = '{ADD,   32'sd1,  32'sd1};
    mem[31] = '{SUB,   32'sd0,  32'sd1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic sweep with latency measurement.
    push_basic4();
    d0 = done_cnt;
    start_pulse(5'd0, 6'd4);
    check("busy_after_start", bus.busy, 1);
    lat = 0;
    while (!bus.res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", lat, 2);
    wait_idle(100);
    check("basic_done_pulses", done_cnt - d0, 1);
    check("basic_queue_empty", exp_q.size(), 0);

    // Error cases, pass-through and extreme arithmetic.
    push(64'sd0,  DIV,   5'd4, 1'b1);
    push(64'sd0,  MOD,   5'd5, 1'b1);
    push(-64'sd1, MOD,   5'd6, 1'b0);
    push(-64'sd5, PASSA, 5'd7, 1'b0);
    push(-64'sd2, PASSB, 5'd8, 1'b0);
    push(64'sd0,  ZERO,  5'd9, 1'b0);
    push(64'sd0,  opcode_t'(4'hB), 5'd10, 1'b1);
    push(64'sh0000_0000_8000_0000, DIV,  5'd11, 1'b0);
    push(64'sh3fff_ffff_0000_0001, MULT, 5'd12, 1'b0);
    push(-64'sd3, DIV,   5'd13, 1'b0);
    d0 = done_cnt;
    start_pulse(5'd4, 6'd10);
    wait_idle(200);
    check("err_done_pulses", done_cnt - d0, 1);
    check("err_queue_empty", exp_q.size(), 0);

    // Address wrap 30,31,0,1.
    push(64'sd2,  ADD, 5'd30, 1'b0);
    push(-64'sd1, SUB, 5'd31, 1'b0);
    push(64'sd8,  ADD, 5'd0,  1'b0);
    push(-64'sd3, SUB, 5'd1,  1'b0);
    start_pulse(5'd30, 6'd4);
    wait_idle(100);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Backpressure: result must hold for 5 cycles.
    bus.res_ready = 1'b0;
    push(64'sd8,  ADD, 5'd0, 1'b0);
    push(-64'sd3, SUB, 5'd1, 1'b0);
    r0 = res_cnt;
    start_pulse(5'd0, 6'd2);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid",   bus.res_valid,    1);
      check("hold_data",    bus.res_data,     64'sd8);
      check("hold_opcode",  bus.res_opcode,   ADD);
      check("hold_addr",    bus.res_addr,     0);
      check("hold_pointer", bus.read_pointer, 0);
    end
    bus.res_ready = 1'b1;
    wait_idle(100);
    check("bp_results", res_cnt - r0, 2);

    // Start while busy is ignored.
    push(64'sd8,  ADD, 5'd0, 1'b0);
    push(-64'sd3, SUB, 5'd1, 1'b0);
    r0 = res_cnt;
    d0 = done_cnt;
    start_pulse(5'd0, 6'd2);
    @(posedge clk); #1;
    start_pulse(5'd5, 6'd3);
    wait_idle(100);
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_results", res_cnt - r0, 2);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_idle_valid", bus.res_valid, 0);

    // count = 0: done pulse only.
    r0 = res_cnt;
    d0 = done_cnt;
    start_pulse(5'd3, 6'd0);
    check("zero_done_high", bus.done, 1);
    check("zero_busy_low", bus.busy, 0);
    @(posedge clk); #1;
    check("zero_done_low", bus.done, 0);
    repeat (6) @(posedge clk);
    #1;
    check("zero_no_results", res_cnt - r0, 0);
    check("zero_done_count", done_cnt - d0, 1);

    // Reset during OUT of the second result.
    bus.res_ready = 1'b0;
    push(64'sd8, ADD, 5'd0, 1'b0);
    d0 = done_cnt;
    start_pulse(5'd0, 6'd4);
    wait_valid(10);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    wait_valid(10);
    check("abort_second_addr", bus.res_addr, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("abort_stays_idle", bus.busy, 0);

    bus.res_ready = 1'b1;
    push_basic4();
    d0 = done_cnt;
    start_pulse(5'd0, 6'd4);
    wait_idle(100);
    check("post_reset_done", done_cnt - d0, 1);
    check("post_reset_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
